ec_point_serializer: RTL and testbench

//  Transmit side for curve_point_t (elliptic_curve_structs): takes one point over valid/ready and

---
 rtl/ec_point_serializer.sv | 127 ++++++++++++
 tb/tb_ec_point_serializer.sv | 317 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ec_point_serializer.sv
// SEC1 point serializer: 0x04 || X || Y as a valid/ready/last byte stream.
// Optional EC_COMPRESSED_POINT_EN adds a compress input (prefix 02/03, X only).
module ec_point_serializer #(
  parameter int MSB_FIRST   = 1,
  parameter int EMIT_PREFIX = 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [511:0] point_in,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [7:0]   out_data,
  output logic         out_last,
  output logic         busy
`ifdef EC_COMPRESSED_POINT_EN
  ,
  input  logic         compress
`endif
);

  typedef enum logic [1:0] {
    IDLE,
    PREFIX,
    XBYTES,
    YBYTES
  } state_t;

  state_t       state;
  logic [255:0] x_r;
  logic [255:0] y_r;
  logic         cmp_r;
  logic [4:0]   cnt;

  logic [255:0] x_in;
  logic [255:0] y_in;
  logic         inf_in;
  logic         cmp_in;
  logic [7:0]   pre_byte;
  logic [4:0]   cnt_n;

  assign x_in   = point_in[511:256];
  assign y_in   = point_in[255:0];
  assign inf_in = (x_in == '0) && (y_in == '0);
  assign cnt_n  = cnt + 5'd1;

`ifdef EC_COMPRESSED_POINT_EN
  assign cmp_in = compress && (EMIT_PREFIX != 0) && !inf_in;
`else
  assign cmp_in = 1'b0;
`endif

  // Compressed prefix carries the parity of y
  assign pre_byte = inf_in ? 8'h00 :
                    cmp_in ? {7'b0000001, y_in[0]} : 8'h04;

  function automatic logic [7:0] pick(
    input logic [255:0] c,
    input logic [4:0]   i
  );
    logic [4:0] k;
    k = (MSB_FIRST != 0) ? ~i : i;
    return c[{k, 3'b000} +: 8];
  endfunction

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      x_r       <= '0;
      y_r       <= '0;
      cmp_r     <= 1'b0;
      cnt       <= 5'd0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      out_data  <= 8'h00;
      out_last  <= 1'b0;
      busy      <= 1'b0;
    end else if (state == IDLE) begin
      if (in_valid && in_ready) begin
        x_r       <= x_in;
        y_r       <= y_in;
        cmp_r     <= cmp_in;
        cnt       <= 5'd0;
        in_ready  <= 1'b0;
        busy      <= 1'b1;
        out_valid <= 1'b1;
        if (EMIT_PREFIX != 0) begin
          state    <= PREFIX;
          out_data <= pre_byte;
          out_last <= inf_in;
        end else begin
          state    <= XBYTES;
          out_data <= pick(x_in, 5'd0);
          out_last <= 1'b0;
        end
      end
    end else if (out_valid && out_ready) begin
      if (out_last) begin
        state     <= IDLE;
        cnt       <= 5'd0;
        out_valid <= 1'b0;
        out_last  <= 1'b0;
        out_data  <= 8'h00;
        busy      <= 1'b0;
        in_ready  <= 1'b1;
      end else if (state == PREFIX) begin
        state    <= XBYTES;
        cnt      <= 5'd0;
        out_data <= pick(x_r, 5'd0);
      end else if (state == XBYTES && cnt == 5'd31) begin
        state    <= YBYTES;
        cnt      <= 5'd0;
        out_data <= pick(y_r, 5'd0);
      end else if (state == XBYTES) begin
        cnt      <= cnt_n;
        out_data <= pick(x_r, cnt_n);
        out_last <= cmp_r && (cnt_n == 5'd31);
      end else begin
        cnt      <= cnt_n;
        out_data <= pick(y_r, cnt_n);
        out_last <= (cnt_n == 5'd31);
      end
    end
  end

endmodule

// File: tb/tb_ec_point_serializer.sv
// Bench for ec_point_serializer: lane 0 prefixed big-endian,
// lane 1 raw little-endian, both checked against a byte-list model.
module tb_ec_point_serializer;

  localparam logic [255:0] GX =
    256'h79BE667EF9DCBBAC55A06295CE870B07029BFCDB2DCE28D959F2815B16F81798;
  localparam logic [255:0] GY =
    256'h483ADA7726A3C4655DA4FBFC0E1108A8FD17B448A68554199C47D08FFB10D4B8;
`ifdef EC_COMPRESSED_POINT_EN
  localparam bit HAS_CMP = 1'b1;
`else
  localparam bit HAS_CMP = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic         iv  [2];
  logic         ir  [2];
  logic         orr [2];
  logic         ov  [2];
  logic         ol  [2];
  logic         bz  [2];
  logic         cm  [2];
  logic [7:0]   od  [2];
  logic [511:0] pt  [2];

  for (genvar g = 0; g < 2; g++) begin : lane
    ec_point_serializer #(
      .MSB_FIRST  (g == 0 ? 1 : 0),
      .EMIT_PREFIX(g == 0 ? 1 : 0)
    ) u (
      .clk      (clk),
      .reset    (reset),
      .in_valid (iv[g]),
      .in_ready (ir[g]),
      .point_in (pt[g]),
      .out_valid(ov[g]),
      .out_ready(orr[g]),
      .out_data (od[g]),
      .out_last (ol[g]),
      .busy     (bz[g])
`ifdef EC_COMPRESSED_POINT_EN
      ,
      .compress (cm[g])
`endif
    );
  end

  typedef struct packed {
    logic [7:0] d;
    logic       l;
  } ob_t;

  ob_t        q  [2][$];
  ob_t        m  [$];
  logic [7:0] lg [2][$];
  int         lc [2][$];
  int         cyc;
  int         pass_n;
  int         tot_n;
  bit         rnd [2];

  // Expected octet list for one point, straight from the SEC1 layout
  function automatic void model(input logic [511:0] p, input bit msb,
                                input bit pfx, input bit c);
    logic [255:0] x, y, v;
    logic [7:0]   b;
    int           n;
    m.delete();
    x = p[511:256];
    y = p[255:0];
    if (pfx && x == '0 && y == '0) begin
      m.push_back('{8'h00, 1'b1});
      return;
    end
    c = c && pfx && HAS_CMP;
    if (pfx) m.push_back('{c ? (8'h02 + {7'd0, y[0]}) : 8'h04, 1'b0});
    n = c ? 1 : 2;
    for (int k = 0; k < n; k++) begin
      v = (k == 0) ? x : y;
      for (int i = 0; i < 32; i++) begin
        b = msb ? 8'(v >> (8 * (31 - i))) : 8'(v >> (8 * i));
        m.push_back('{b, (k == n - 1) && (i == 31)});
      end
    end
  endfunction

  task automatic chk(input bit ok, input string nm,
                     input logic [63:0] a, input logic [63:0] e);
    tot_n++;
    if (ok) pass_n++;
    else $display("FAIL %s t=%0t actual=%0h required=%0h", nm, $time, a, e);
  endtask

  task automatic mon();
    forever begin
      @(negedge clk);
      cyc++;
      for (int l = 0; l < 2; l++) begin
        if (reset) begin
          chk(ir[l] && !ov[l] && od[l] == 8'h00 && !ol[l] && !bz[l],
              $sformatf("reset_state_l%0d", l),
              64'({ir[l], ov[l], ol[l], bz[l], od[l]}),
              64'({1'b1, 1'b0, 1'b0, 1'b0, 8'h00}));
          q[l].delete();
        end else begin
          bit e;
          e = (q[l].size() == 0);
          chk(ov[l] == !e && bz[l] == !e && ir[l] == e,
              $sformatf("flags_l%0d", l),
              64'({ov[l], bz[l], ir[l]}), 64'({!e, !e, e}));
          if (ov[l] && !e) begin
            chk(od[l] == q[l][0].d && ol[l] == q[l][0].l,
                $sformatf("byte_l%0d", l),
                64'({od[l], ol[l]}), 64'({q[l][0].d, q[l][0].l}));
            if (orr[l]) begin
              lg[l].push_back(od[l]);
              lc[l].push_back(cyc);
              void'(q[l].pop_front());
            end
          end
          if (iv[l] && ir[l]) begin
            model(pt[l], l == 0, l == 0, cm[l]);
            foreach (m[i]) q[l].push_back(m[i]);
          end
        end
      end
    end
  endtask

  task automatic ready_drv();
    forever begin
      @(posedge clk);
      #1;
      for (int l = 0; l < 2; l++)
        orr[l] = rnd[l] ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  endtask

  task automatic send(input int l, input logic [511:0] p, input bit c);
    bit hs;
    int n;
    n = 0;
    pt[l] = p;
    cm[l] = c;
    iv[l] = 1'b1;
    do begin
      hs = ir[l];
      @(posedge clk);
      #1;
      n++;
    end while (!hs && n < 500);
    iv[l] = 1'b0;
    if (!hs) chk(1'b0, "send_timeout", 64'(n), 64'd500);
  endtask

  task automatic wait_idle(input int l);
    int n;
    n = 0;
    while ((q[l].size() != 0 || ov[l]) && n < 3000) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (n >= 3000) chk(1'b0, "idle_timeout", 64'(n), 64'd3000);
  endtask

  task automatic clr();
    for (int l = 0; l < 2; l++) begin
      lg[l].delete();
      lc[l].delete();
    end
  endtask

  function automatic logic [255:0] r256();
    logic [255:0] v;
    for (int i = 0; i < 8; i++) v[32*i +: 32] = $urandom;
    return v;
  endfunction

  initial begin
    logic [255:0] xr;
    int           n;
    reset = 1'b1;
    cyc = 0;
    pass_n = 0;
    tot_n = 0;
    for (int l = 0; l < 2; l++) begin
      iv[l] = 1'b0;
      orr[l] = 1'b1;
      cm[l] = 1'b0;
      pt[l] = '0;
      rnd[l] = 1'b0;
    end
    fork
      mon();
      ready_drv();
    join_none
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    model({GX, GY}, 1'b1, 1'b1, 1'b0);
    chk(m.size() == 65 && m[0].d == 8'h04 && m[1].d == 8'h79 &&
        m[64].d == 8'hB8 && m[64].l && !m[63].l,
        "model_g", 64'(m.size()), 64'd65);
    model({GX, GY}, 1'b0, 1'b0, 1'b0);
    chk(m.size() == 64 && m[0].d == 8'h98 && m[31].d == 8'h79 &&
        m[32].d == 8'hB8 && m[63].d == 8'h48,
        "model_le", 64'(m.size()), 64'd64);

    // G, always ready
    clr();
    send(0, {GX, GY}, 1'b0);
    wait_idle(0);
    chk(lg[0].size() == 65, "t1_len", 64'(lg[0].size()), 64'd65);
    if (lg[0].size() == 65) begin
      chk(lg[0][0] == 8'h04, "t1_b0", 64'(lg[0][0]), 64'h04);
      chk(lg[0][1] == 8'h79, "t1_b1", 64'(lg[0][1]), 64'h79);
      chk(lg[0][32] == 8'h98, "t1_b32", 64'(lg[0][32]), 64'h98);
      chk(lg[0][33] == 8'h48, "t1_b33", 64'(lg[0][33]), 64'h48);
      chk(lg[0][64] == 8'hB8, "t1_b64", 64'(lg[0][64]), 64'hB8);
      chk(lc[0][64] - lc[0][0] == 64, "t1_b2b",
          64'(lc[0][64] - lc[0][0]), 64'd64);
    end

    // G with a stalling sink
    clr();
    rnd[0] = 1'b1;
    send(0, {GX, GY}, 1'b0);
    wait_idle(0);
    rnd[0] = 1'b0;
    chk(lg[0].size() == 65, "t2_len", 64'(lg[0].size()), 64'd65);
    if (lg[0].size() == 65)
      chk(lg[0][20] == 8'hDB && lg[0][64] == 8'hB8, "t2_bytes",
          64'({lg[0][20], lg[0][64]}), 64'hDBB8);

    // Point at infinity on both lanes
    clr();
    send(0, '0, 1'b0);
    wait_idle(0);
    send(1, '0, 1'b0);
    wait_idle(1);
    chk(lg[0].size() == 1, "t3_inf_len", 64'(lg[0].size()), 64'd1);
    chk(lg[1].size() == 64, "t3_raw_len", 64'(lg[1].size()), 64'd64);

    // Little-endian raw lane
    clr();
    send(1, {GX, GY}, 1'b0);
    wait_idle(1);
    chk(lg[1].size() == 64, "t4_len", 64'(lg[1].size()), 64'd64);
    if (lg[1].size() == 64)
      chk(lg[1][0] == 8'h98 && lg[1][31] == 8'h79 &&
          lg[1][32] == 8'hB8 && lg[1][63] == 8'h48, "t4_bytes",
          64'({lg[1][0], lg[1][31], lg[1][32], lg[1][63]}), 64'h9879B848);

`ifdef EC_COMPRESSED_POINT_EN
    clr();
    send(0, {GX, GY}, 1'b1);
    wait_idle(0);
    chk(lg[0].size() == 33, "t5_len", 64'(lg[0].size()), 64'd33);
    if (lg[0].size() == 33)
      chk(lg[0][0] == 8'h02 && lg[0][32] == 8'h98, "t5_even",
          64'({lg[0][0], lg[0][32]}), 64'h0298);
    clr();
    send(0, {GX, GY | 256'd1}, 1'b1);
    wait_idle(0);
    chk(lg[0].size() == 33 && lg[0][0] == 8'h03, "t5_odd",
        64'(lg[0].size() > 0 ? lg[0][0] : 8'hFF), 64'h03);
`endif

    // Reset mid-stream, then a fresh point
    clr();
    send(0, {GX, GY}, 1'b0);
    n = 0;
    while (lg[0].size() < 20 && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk(lg[0].size() == 20, "t6_reach20", 64'(lg[0].size()), 64'd20);
    reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    clr();
    xr = r256();
    send(0, {xr, GY}, 1'b0);
    wait_idle(0);
    chk(lg[0].size() == 65, "t6_len", 64'(lg[0].size()), 64'd65);
    if (lg[0].size() == 65)
      chk(lg[0][0] == 8'h04 && lg[0][1] == xr[255:248], "t6_head",
          64'({lg[0][0], lg[0][1]}), 64'({8'h04, xr[255:248]}));

    // Random traffic with random back-pressure
    rnd[0] = 1'b1;
    rnd[1] = 1'b1;
    for (int it = 0; it < 30; it++) begin
      int          l;
      int          k;
      logic [511:0] p;
      l = int'($urandom_range(0, 1));
      k = int'($urandom_range(0, 9));
      p = {r256(), r256()};
      if (k == 0) p = '0;
      if (k == 1) p[511:256] = '0;
      send(l, p, 1'($urandom_range(0, 1)));
      if (k > 6) wait_idle(l);
    end
    wait_idle(0);
    wait_idle(1);

    $display("%0d/%0d checks passed", pass_n, tot_n);
    $finish;
  end

endmodule
